branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Two-level local branch predictor, the counterpart of the pipeline's prediction interface.
- In F it takes pcF and returns a prediction combinationally, together with the BHT and PHT indices used. The pipeline carries those indices down to M.
- In M it consumes the resolved outcome (branchM, actually_takenM, indices) and trains the tables.
- It sits beside the datapath and holds no pipeline registers of its own.

Parameters:
- PC_HASH_BITS, 3: BHT index width; BHT has 2**PC_HASH_BITS entries.
- BHR_BITS, 4: local history length per BHT entry.
- PHT_INDEX_BITS, 7: PHT index width; must equal BHR_BITS+PC_HASH_BITS (elaboration-time assertion).
- STAT_W, 32: width of the statistics counters (optional feature only).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- pcF  in  32  fetch PC.
- predict_takeF  out  1  predicted direction for pcF.
- pc_hashingF  out  PC_HASH_BITS  BHT index for pcF.
- PHT_indexF  out  PHT_INDEX_BITS  PHT index for pcF.
- branchM  in  1  the M-stage instruction is a branch; update strobe.
- actually_takenM  in  1  resolved direction.
- pc_hashingM  in  PC_HASH_BITS  BHT index captured at F.
- PHT_indexM  in  PHT_INDEX_BITS  PHT index captured at F.
- predict_resultM  in  1  1 = prediction correct or not a branch (statistics only).
- branch_cntS  out  STAT_W  retired branches (BP_STATS_EN only).
- mispredict_cntS  out  STAT_W  mispredicted branches (BP_STATS_EN only).

Behaviour:
- Hash:
  - pc_hashingF = pcF[PC_HASH_BITS+1:2].
  - PHT_indexF = {BHT[pc_hashingF], pc_hashingF}.
- Prediction: predict_takeF = PHT[PHT_indexF][1]. Purely combinational, zero latency, no clock dependency.
- PHT:
  - 2**PHT_INDEX_BITS 2-bit saturating counters: 00 SNT, 01 WNT, 10 WT, 11 ST.
- Update (rising clk, branchM=1 only):
  - PHT[PHT_indexM] +1 if actually_takenM, saturating at 11.
  - PHT[PHT_indexM] -1 otherwise, saturating at 00.
  - BHT[pc_hashingM] <= {BHT[pc_hashingM][BHR_BITS-2:0], actually_takenM}.
- branchM=0: no state change, whatever the other M inputs are.
- Update indices are used as given. They are never recomputed from the current BHT. PHT and BHT updates are independent, even if the PHT_indexM lower bits disagree with pc_hashingM.
- Read/write collision: if PHT_indexF equals PHT_indexM in an update cycle, predict_takeF shows the pre-update value. The new value is visible from the next cycle. There is no bypass. The same rule applies to the BHT.
- Reset (rst=0, asynchronous, any time including mid-update):
  - All BHT entries go to 0.
  - All PHT entries go to 01 (WNT).
  - Statistics counters go to 0.
  - So predict_takeF=0 as soon as rst falls.
  - A pending update on the same edge as reset release is ignored.
- Updates are non-speculative: history changes only from M.

Optional Feature:
- Macro: BP_STATS_EN.
- Defined:
  - On each rising clk with branchM=1, branch_cntS increments.
  - If also predict_resultM=0, mispredict_cntS increments.
  - Both wrap modulo 2**STAT_W.
- Undefined: the two ports and their counters are absent from the port list and the logic.

Decomposition:
- Package bp_pkg holds:
  - PC_HASH_BITS, BHR_BITS and PHT_INDEX_BITS defaults;
  - typedef enum logic [1:0] sat2_t {SNT, WNT, WT, ST};
  - the reset constant PHT_INIT = WNT.
- One sub-module, bp_pht:
  - counter array with async read, synchronous saturating update and async reset;
  - ports: clk, rst, raddr, rdata, we, waddr, taken.
- The BHT stays inline in branch_predictor.

Test Plan:
- Reset value:
  - Release rst, pcF=0x00400014 -> pc_hashingF=5, PHT_indexF=0x05, predict_takeF=0.
- Train:
  - One update with branchM=1, taken=1, PHT_indexM=0x05, pc_hashingM=2 -> next cycle pcF=0x00400014 gives PHT_indexF=0x05, predict_takeF=1.
  - pcF=0x00400008 gives PHT_indexF=0x0A (BHT[2]=0001).
- Saturation:
  - Four taken updates to 0x05, then one not-taken -> predict_takeF=1.
  - A second not-taken -> predict_takeF=0.
  - Three further not-taken then one taken -> still 0 (counter at 01).
- No-op:
  - branchM=0, actually_takenM=1, PHT_indexM=0x05 for 10 cycles -> predict_takeF and all indices unchanged.
- Collision:
  - pcF indexes 0x05 during a taken update taking it 01->10 -> predict_takeF=0 in that cycle, 1 the next.
- Async reset and stats:
  - rst low between edges after training -> predict_takeF=0 and PHT_indexF=pc_hashingF immediately.
  - With BP_STATS_EN: 3 branch updates, one with predict_resultM=0 -> branch_cntS=3, mispredict_cntS=1; after reset both read 0.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types and defaults for the two-level local branch predictor.
package bp_pkg;

    localparam int PC_HASH_BITS_DEF   = 3;
    localparam int BHR_BITS_DEF       = 4;
    localparam int PHT_INDEX_BITS_DEF = 7;
    localparam int STAT_W_DEF         = 32;

    typedef enum logic [1:0] {SNT, WNT, WT, ST} sat2_t;

    localparam sat2_t PHT_INIT = WNT;

    // Saturating step of a 2-bit direction counter toward the resolved outcome.
    function automatic sat2_t sat2Next(input sat2_t cur, input logic taken);
        sat2_t nxt;
        nxt = cur;
        case (cur)
            SNT: nxt = taken ? WNT : SNT;
            WNT: nxt = taken ? WT  : SNT;
            WT:  nxt = taken ? ST  : WNT;
            ST:  nxt = taken ? ST  : WT;
            default: nxt = PHT_INIT;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch-side prediction and M-side training signals between pipeline and predictor.
interface branch_predictor_if
    import bp_pkg::*;
#(
    parameter int PC_HASH_BITS   = PC_HASH_BITS_DEF,
    parameter int PHT_INDEX_BITS = PHT_INDEX_BITS_DEF
);

    logic [31:0]               pcF;
    logic                      predict_takeF;
    logic [PC_HASH_BITS-1:0]   pc_hashingF;
    logic [PHT_INDEX_BITS-1:0] PHT_indexF;

    logic                      branchM;
    logic                      actually_takenM;
    logic [PC_HASH_BITS-1:0]   pc_hashingM;
    logic [PHT_INDEX_BITS-1:0] PHT_indexM;
    logic                      predict_resultM;

    modport master (
        output pcF, branchM, actually_takenM, pc_hashingM, PHT_indexM, predict_resultM,
        input  predict_takeF, pc_hashingF, PHT_indexF
    );

    modport slave (
        input  pcF, branchM, actually_takenM, pc_hashingM, PHT_indexM, predict_resultM,
        output predict_takeF, pc_hashingF, PHT_indexF
    );

endinterface

// File: rtl/bp_pht.sv
// Pattern history table: 2-bit saturating counters, async read, clocked update.
module bp_pht
    import bp_pkg::*;
#(
    parameter int IDX_W = PHT_INDEX_BITS_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] raddr,
    output sat2_t            rdata,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic             taken
);

    localparam int DEPTH = 2 ** IDX_W;

    sat2_t pht_q [DEPTH];
    sat2_t pht_d;

    // Read is combinational so a same-cycle write is not visible until the next cycle.
    assign rdata = pht_q[raddr];
    assign pht_d = sat2Next(pht_q[waddr], taken);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pht_q[i] <= PHT_INIT;
            end
        end else if (we) begin
            pht_q[waddr] <= pht_d;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Two-level local branch predictor: inline per-PC history table feeding bp_pht.
// Optional retired/mispredict counters are built when BP_STATS_EN is defined.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int PC_HASH_BITS   = PC_HASH_BITS_DEF,
    parameter int BHR_BITS       = BHR_BITS_DEF,
    parameter int PHT_INDEX_BITS = PHT_INDEX_BITS_DEF,
    parameter int STAT_W         = STAT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    branch_predictor_if.slave bp
`ifdef BP_STATS_EN
    ,
    output logic [STAT_W-1:0] branch_cntS,
    output logic [STAT_W-1:0] mispredict_cntS
`endif
);

    localparam int BHT_DEPTH = 2 ** PC_HASH_BITS;

    if (PHT_INDEX_BITS != BHR_BITS + PC_HASH_BITS) begin : gIndexCheck
        $error("branch_predictor: PHT_INDEX_BITS must equal BHR_BITS + PC_HASH_BITS");
    end

    logic                      armed_q;
    logic                      updEn;
    logic [BHR_BITS-1:0]       bht_q [BHT_DEPTH];
    logic [BHR_BITS-1:0]       bht_d;
    logic [PC_HASH_BITS-1:0]   hashF;
    sat2_t                     phtRd;

    // armed_q stays low through the first edge after reset release, so an
    // update presented on that edge is dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            armed_q <= 1'b0;
        end else begin
            armed_q <= 1'b1;
        end
    end

    assign updEn = bp.branchM && armed_q;

    assign hashF            = bp.pcF[PC_HASH_BITS+1:2];
    assign bp.pc_hashingF   = hashF;
    assign bp.PHT_indexF    = {bht_q[hashF], hashF};
    assign bp.predict_takeF = phtRd[1];

    // Training uses the indices captured at fetch, never a fresh BHT lookup.
    assign bht_d = {bht_q[bp.pc_hashingM][BHR_BITS-2:0], bp.actually_takenM};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht_q[i] <= '0;
            end
        end else if (updEn) begin
            bht_q[bp.pc_hashingM] <= bht_d;
        end
    end

    bp_pht #(
        .IDX_W (PHT_INDEX_BITS)
    ) uPht (
        .clk   (clk),
        .rst   (rst),
        .raddr (bp.PHT_indexF),
        .rdata (phtRd),
        .we    (updEn),
        .waddr (bp.PHT_indexM),
        .taken (bp.actually_takenM)
    );

`ifdef BP_STATS_EN
    logic [STAT_W-1:0] branch_cnt_q;
    logic [STAT_W-1:0] mispredict_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else if (updEn) begin
            branch_cnt_q <= branch_cnt_q + 1'b1;
            if (!bp.predict_resultM) begin
                mispredict_cnt_q <= mispredict_cnt_q + 1'b1;
            end
        end
    end

    assign branch_cntS     = branch_cnt_q;
    assign mispredict_cntS = mispredict_cnt_q;

    logic unused_pc;
    assign unused_pc = ^{bp.pcF[31:PC_HASH_BITS+2], bp.pcF[1:0]};
`else
    localparam int unused_statW = STAT_W;

    logic unused_sig;
    assign unused_sig = ^{bp.pcF[31:PC_HASH_BITS+2], bp.pcF[1:0], bp.predict_resultM};
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Randomized and directed check of branch_predictor against an array-based model.
// Counter checks are included when BP_STATS_EN is defined.
module tb_branch_predictor;

    logic clk;
    logic rst;

    int vectors;
    int miscompares;

    int bhtM [8];
    int phtM [128];
    int branchesM;
    int mispredM;

    branch_predictor_if #(.PC_HASH_BITS(3), .PHT_INDEX_BITS(7)) bpIf ();

`ifdef BP_STATS_EN
    logic [31:0] branch_cntS;
    logic [31:0] mispredict_cntS;
`endif

    branch_predictor #(
        .PC_HASH_BITS   (3),
        .BHR_BITS       (4),
        .PHT_INDEX_BITS (7),
        .STAT_W         (32)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .bp              (bpIf.slave)
`ifdef BP_STATS_EN
        ,
        .branch_cntS     (branch_cntS),
        .mispredict_cntS (mispredict_cntS)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic int modelHash(input logic [31:0] pc);
        return int'((pc >> 2) % 8);
    endfunction

    function automatic int modelIndex(input logic [31:0] pc);
        return bhtM[modelHash(pc)] * 8 + modelHash(pc);
    endfunction

    function automatic int modelPredict(input logic [31:0] pc);
        return (phtM[modelIndex(pc)] >= 2) ? 1 : 0;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 8; i++) bhtM[i] = 0;
        for (int i = 0; i < 128; i++) phtM[i] = 1;
        branchesM = 0;
        mispredM  = 0;
    endtask

    // One cycle: drive at negedge, check the fetch outputs, then train the model at the edge.
    task automatic applyStimulus(input logic [31:0] pc, input logic br, input logic tk,
                                 input logic [2:0] hM, input logic [6:0] pM, input logic pr);
        @(negedge clk);
        bpIf.pcF             = pc;
        bpIf.branchM         = br;
        bpIf.actually_takenM = tk;
        bpIf.pc_hashingM     = hM;
        bpIf.PHT_indexM      = pM;
        bpIf.predict_resultM = pr;
        #1;
        checkOutput("hashF", 32'(bpIf.pc_hashingF), 32'(modelHash(pc)));
        checkOutput("idxF",  32'(bpIf.PHT_indexF),  32'(modelIndex(pc)));
        checkOutput("predF", 32'(bpIf.predict_takeF), 32'(modelPredict(pc)));
        @(posedge clk);
        if (br) begin
            if (tk) phtM[pM] = (phtM[pM] == 3) ? 3 : phtM[pM] + 1;
            else    phtM[pM] = (phtM[pM] == 0) ? 0 : phtM[pM] - 1;
            bhtM[hM] = (bhtM[hM] * 2 + int'(tk)) % 16;
            branchesM++;
            if (!pr) mispredM++;
        end
    endtask

    task automatic checkFetch(input string tag, input logic [31:0] pc,
                              input logic [31:0] expIdx, input logic expPred);
        @(negedge clk);
        bpIf.pcF     = pc;
        bpIf.branchM = 1'b0;
        #1;
        checkOutput({tag, "_idx"},  32'(bpIf.PHT_indexF), expIdx);
        checkOutput({tag, "_pred"}, 32'(bpIf.predict_takeF), 32'(expPred));
    endtask

    // Reset asserted between edges must clear the prediction immediately.
    task automatic applyReset();
        @(negedge clk);
        #2;
        rst          = 1'b0;
        bpIf.branchM = 1'b0;
        #1;
        modelReset();
        checkOutput("rstPred", 32'(bpIf.predict_takeF), 32'd0);
        checkOutput("rstIdx",  32'(bpIf.PHT_indexF), 32'(modelHash(bpIf.pcF)));
        @(negedge clk);
        #2;
        rst = 1'b1;
        applyStimulus(32'h0, 1'b0, 1'b0, 3'd0, 7'd0, 1'b1);
        applyStimulus(32'h0, 1'b0, 1'b0, 3'd0, 7'd0, 1'b1);
    endtask

    initial begin
        logic [31:0] pc;
        logic [2:0]  hM;
        logic [6:0]  pM;

        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        bpIf.pcF             = 32'h0;
        bpIf.branchM         = 1'b0;
        bpIf.actually_takenM = 1'b0;
        bpIf.pc_hashingM     = '0;
        bpIf.PHT_indexM      = '0;
        bpIf.predict_resultM = 1'b1;
        modelReset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(32'h0, 1'b0, 1'b0, 3'd0, 7'd0, 1'b1);
        applyStimulus(32'h0, 1'b0, 1'b0, 3'd0, 7'd0, 1'b1);

        checkFetch("reset", 32'h0040_0014, 32'h05, 1'b0);
        checkOutput("resetHash", 32'(bpIf.pc_hashingF), 32'd5);

        applyStimulus(32'h0, 1'b1, 1'b1, 3'd2, 7'h05, 1'b1);
        checkFetch("train", 32'h0040_0014, 32'h05, 1'b1);
        checkFetch("trainBht", 32'h0040_0008, 32'h0A, 1'b0);

        repeat (4) applyStimulus(32'h0, 1'b1, 1'b1, 3'd3, 7'h05, 1'b1);
        applyStimulus(32'h0, 1'b1, 1'b0, 3'd3, 7'h05, 1'b1);
        checkFetch("satHigh", 32'h0040_0014, 32'h05, 1'b1);
        applyStimulus(32'h0, 1'b1, 1'b0, 3'd3, 7'h05, 1'b1);
        checkFetch("satDrop", 32'h0040_0014, 32'h05, 1'b0);
        repeat (3) applyStimulus(32'h0, 1'b1, 1'b0, 3'd3, 7'h05, 1'b1);
        applyStimulus(32'h0, 1'b1, 1'b1, 3'd3, 7'h05, 1'b1);
        checkFetch("satLow", 32'h0040_0014, 32'h05, 1'b0);

        applyStimulus(32'h0040_0014, 1'b1, 1'b1, 3'd3, 7'h05, 1'b1);
        checkOutput("collideSame", 32'(bpIf.predict_takeF), 32'd0);
        checkFetch("collideNext", 32'h0040_0014, 32'h05, 1'b1);

        repeat (10) applyStimulus(32'h0040_0014, 1'b0, 1'b1, 3'd5, 7'h05, 1'b0);
        checkFetch("noop", 32'h0040_0014, 32'h05, 1'b1);
        checkFetch("noopBht", 32'h0040_0008, 32'h0A, 1'b0);

        for (int n = 0; n < 400; n++) begin
            pc = $urandom;
            hM = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) pM = 7'($urandom_range(0, 127));
            else                           pM = 7'($urandom_range(0, 3) * 8 + int'(hM));
            applyStimulus(pc, ($urandom_range(0, 9) < 7), 1'($urandom), hM, pM, 1'($urandom));
        end

        bpIf.pcF = $urandom;
        applyReset();
        checkFetch("postReset", 32'h0040_0014, 32'h05, 1'b0);

`ifdef BP_STATS_EN
        applyStimulus(32'h0, 1'b1, 1'b1, 3'd1, 7'h11, 1'b1);
        applyStimulus(32'h0, 1'b1, 1'b0, 3'd1, 7'h19, 1'b0);
        applyStimulus(32'h0, 1'b1, 1'b1, 3'd4, 7'h0C, 1'b1);
        @(negedge clk);
        bpIf.branchM = 1'b0;
        #1;
        checkOutput("branchCnt", branch_cntS, 32'(branchesM));
        checkOutput("mispredCnt", mispredict_cntS, 32'(mispredM));
        checkOutput("branchCnt3", branch_cntS, 32'd3);
        checkOutput("mispredCnt1", mispredict_cntS, 32'd1);
        applyReset();
        checkOutput("branchCntRst", branch_cntS, 32'd0);
        checkOutput("mispredCntRst", mispredict_cntS, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
